// File: rtl/lcd_cmd_host_if.sv
// Command/pixel link between the LCD host initiator and the LCD controller.
// The master side issues commands and streams pixels; the slave side returns the window.
interface lcd_cmd_if;
  logic [3:0] cmd;
  logic       cmd_valid;
  logic [7:0] datain;
  logic       busy;
  logic [7:0] dataout;
  logic       output_valid;

  modport master (output cmd, output cmd_valid, output datain,
                  input  busy, input dataout, input output_valid);
  modport slave  (input  cmd, input cmd_valid, input datain,
                  output busy, output dataout, output output_valid);
endinterface

// File: rtl/lcd_cmd_host.sv
// Script-driven LCD command initiator: fetches commands from a script ROM, issues them when
// the controller is idle, streams the image after LOAD and captures the returned pixel window.
module lcd_cmd_host #(
  parameter int unsigned IMG_PIXELS = 108,
  parameter int unsigned OUT_PIXELS = 16,
  parameter int unsigned SCRIPT_AW  = 6,
  parameter int unsigned TIMEOUT    = 1023
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_start,
  output logic [SCRIPT_AW-1:0] o_script_addr,
  input  logic [3:0]           i_script_data,
  output logic [6:0]           o_img_addr,
  input  logic [7:0]           i_img_data,
  lcd_cmd_if.master            lcd,
  output logic                 o_win_we,
  output logic [3:0]           o_win_addr,
  output logic [7:0]           o_win_data,
  output logic                 o_resp_done,
  output logic                 o_done,
  output logic                 o_err
);

  localparam int unsigned PW = 8;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [3:0]  CMD_LOAD = 4'h0;
  localparam logic [3:0]  CMD_END  = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ISSUE, S_LOAD, S_GUARD, S_WAIT, S_DONE
  } state_t;

  state_t               r_state;
  logic [SCRIPT_AW-1:0] r_ptr;
  logic [6:0]           r_k;
  logic [PW-1:0]        r_pix;
  logic [TW-1:0]        r_wait;
  logic [3:0]           r_cmd;
  logic                 r_cmd_valid;
  logic [7:0]           r_datain;
  logic                 r_win_we;
  logic [3:0]           r_win_addr;
  logic [7:0]           r_win_data;
  logic                 r_resp_done;
  logic                 r_done;
  logic                 r_err;

  logic                 w_timeout;
  logic                 w_pix_take;
  logic [PW:0]          w_pix_total;

  assign w_timeout   = (r_wait == TW'(TIMEOUT));
  assign w_pix_take  = lcd.output_valid && (r_pix < PW'(OUT_PIXELS));
  // Pixel arriving in the same cycle busy drops still counts toward the response.
  assign w_pix_total = {1'b0, r_pix} + (PW+1)'(lcd.output_valid);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_k         <= '0;
      r_pix       <= '0;
      r_wait      <= '0;
      r_cmd       <= '0;
      r_cmd_valid <= 1'b0;
      r_datain    <= '0;
      r_win_we    <= 1'b0;
      r_win_addr  <= '0;
      r_win_data  <= '0;
      r_resp_done <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_cmd_valid <= 1'b0;
      r_win_we    <= 1'b0;
      r_resp_done <= 1'b0;
      if (!w_timeout) r_wait <= r_wait + TW'(1);

      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_ptr   <= '0;
            r_wait  <= '0;
            r_state <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (i_script_data == CMD_END) begin
            r_done  <= 1'b1;
            r_wait  <= '0;
            r_state <= S_DONE;
          end else if (!lcd.busy) begin
            r_cmd       <= i_script_data;
            r_cmd_valid <= 1'b1;
            r_k         <= '0;
            r_wait      <= '0;
            r_state     <= S_ISSUE;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_done  <= 1'b1;
            r_wait  <= '0;
            r_state <= S_DONE;
          end
        end
        S_ISSUE: begin
          r_wait <= '0;
          if (r_cmd == CMD_LOAD) begin
            r_datain <= i_img_data;
            r_k      <= r_k + 7'(1);
            r_state  <= S_LOAD;
          end else begin
            r_state  <= S_GUARD;
          end
        end
        // r_k runs one ahead of the pixel on datain; all pixels are out once it hits IMG_PIXELS.
        S_LOAD: begin
          if (r_k == 7'(IMG_PIXELS)) begin
            r_k     <= '0;
            r_wait  <= '0;
            r_state <= S_GUARD;
          end else begin
            r_datain <= i_img_data;
            r_k      <= r_k + 7'(1);
          end
        end
        S_GUARD: begin
          r_wait  <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (w_pix_take) begin
            r_win_we   <= 1'b1;
            r_win_addr <= r_pix[3:0];
            r_win_data <= lcd.dataout;
          end
          if (lcd.output_valid && (r_pix != '1)) r_pix <= r_pix + PW'(1);
          if (!lcd.busy) begin
            r_resp_done <= 1'b1;
            r_ptr       <= r_ptr + SCRIPT_AW'(1);
            r_pix       <= '0;
            if (w_pix_total != (PW+1)'(OUT_PIXELS)) r_err <= 1'b1;
            r_wait      <= '0;
            r_state     <= S_FETCH;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_done  <= 1'b1;
            r_pix   <= '0;
            r_wait  <= '0;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (i_start) begin
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_ptr   <= '0;
            r_wait  <= '0;
            r_state <= S_FETCH;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_script_addr = r_ptr;
  assign o_img_addr    = r_k;
  assign lcd.cmd       = r_cmd;
  assign lcd.cmd_valid = r_cmd_valid;
  assign lcd.datain    = r_datain;
  assign o_win_we      = r_win_we;
  assign o_win_addr    = r_win_addr;
  assign o_win_data    = r_win_data;
  assign o_resp_done   = r_resp_done;
  assign o_done        = r_done;
  assign o_err         = r_err;

endmodule

// File: tb/tb_lcd_cmd_host.sv
// Bench for lcd_cmd_host: behavioural LCD controller plus a command/response-level model
// of what the host must issue, stream and capture for a given script.
module tb_lcd_cmd_host;
  localparam int IMG_PIXELS = 108;
  localparam int OUT_PIXELS = 16;
  localparam int TIMEOUT    = 1023;

  logic       clk;
  logic       reset;
  logic       i_start;
  logic [5:0] o_script_addr;
  logic [3:0] i_script_data;
  logic [6:0] o_img_addr;
  logic [7:0] i_img_data;
  logic       o_win_we;
  logic [3:0] o_win_addr;
  logic [7:0] o_win_data;
  logic       o_resp_done;
  logic       o_done;
  logic       o_err;

  lcd_cmd_if lcd();

  logic [3:0] rom [64];
  logic [7:0] img [128];
  assign i_script_data = rom[o_script_addr];
  assign i_img_data    = img[o_img_addr];

  lcd_cmd_host #(.IMG_PIXELS(IMG_PIXELS), .OUT_PIXELS(OUT_PIXELS), .SCRIPT_AW(6), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .i_start(i_start),
    .o_script_addr(o_script_addr), .i_script_data(i_script_data),
    .o_img_addr(o_img_addr), .i_img_data(i_img_data),
    .lcd(lcd),
    .o_win_we(o_win_we), .o_win_addr(o_win_addr), .o_win_data(o_win_data),
    .o_resp_done(o_resp_done), .o_done(o_done), .o_err(o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;

  // Scenario description: script commands and reply pixel count per command (-1 = never reply).
  int scr [$];
  int npix_a [16];

  // Observations from one script run.
  logic [3:0] ob_cmds [$];
  int ob_wa [$];
  int ob_wd [$];
  int sent_pix [$];
  int ob_resp, ob_dbad, ob_bviol, ob_b2b, ob_err_lat;
  bit ob_timeout, ob_done, ob_err, ob_done_as, ob_err_as;

  // Expected results of one script run.
  logic [3:0] exp_cmds [$];
  int exp_wa [$];
  int exp_wd [$];
  int exp_resp;
  bit exp_err;

  function automatic void setup(input int n_default);
    foreach (npix_a[i]) npix_a[i] = n_default;
    for (int i = 0; i < 64; i++) rom[i] = 4'hF;
    foreach (scr[i]) rom[i] = 4'(scr[i]);
  endfunction

  function automatic logic [41:0] outs();
    return {o_script_addr, o_img_addr, lcd.cmd, lcd.cmd_valid, lcd.datain,
            o_win_we, o_win_addr, o_win_data, o_resp_done, o_done, o_err};
  endfunction

  // Command-level model: each command is issued once; a reply of n pixels fills window
  // slots 0..min(n,16)-1 in order; any n other than 16 flags err; a silent reply ends the run.
  function automatic void build_exp();
    int base = 0;
    int n;
    exp_cmds.delete(); exp_wa.delete(); exp_wd.delete();
    exp_resp = 0; exp_err = 1'b0;
    foreach (scr[i]) begin
      n = npix_a[i];
      exp_cmds.push_back(4'(scr[i]));
      if (n < 0) begin exp_err = 1'b1; break; end
      exp_resp++;
      if (n != OUT_PIXELS) exp_err = 1'b1;
      for (int p = 0; p < n && p < OUT_PIXELS; p++) begin
        exp_wa.push_back(p);
        exp_wd.push_back(sent_pix[base + p]);
      end
      base += n;
    end
  endfunction

  function automatic int cmd_diff();
    int d = (ob_cmds.size() != exp_cmds.size()) ? 1 : 0;
    for (int i = 0; i < ob_cmds.size() && i < exp_cmds.size(); i++)
      if (ob_cmds[i] !== exp_cmds[i]) d++;
    return d;
  endfunction

  function automatic int wr_diff();
    int d = (ob_wa.size() != exp_wa.size()) ? 1 : 0;
    for (int i = 0; i < ob_wa.size() && i < exp_wa.size(); i++)
      if (ob_wa[i] != exp_wa[i] || ob_wd[i] != exp_wd[i]) d++;
    return d;
  endfunction

  // Pulses start, then acts as the LCD controller cycle by cycle until done or the budget runs out.
  task automatic run_script(input int abort_k, input int mid_start, input bit seq_pix);
    int cmd_cyc = 0, r_start = 0, r_end = 0, kc = -1, base = 0, n;
    bit load = 1'b0, active = 1'b0, prev_cv = 1'b0;
    ob_cmds.delete(); ob_wa.delete(); ob_wd.delete(); sent_pix.delete();
    ob_resp = 0; ob_dbad = 0; ob_bviol = 0; ob_b2b = 0; ob_err_lat = -1;
    ob_timeout = 1'b0; ob_done = 1'b0; ob_err = 1'b0;
    lcd.busy = 1'b0; lcd.output_valid = 1'b0; lcd.dataout = 8'h00;
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    ob_done_as = o_done;
    ob_err_as  = o_err;
    for (int cyc = 1; cyc < 6000; cyc++) begin
      if (lcd.cmd_valid) begin
        if (prev_cv) ob_b2b++;
        if (lcd.busy) ob_bviol++;
        ob_cmds.push_back(lcd.cmd);
        kc++;
        cmd_cyc = cyc;
        load    = (lcd.cmd == 4'h0);
        active  = 1'b1;
        n       = npix_a[kc & 15];
        r_start = cyc + 2 + (load ? IMG_PIXELS : 0) + int'($urandom_range(0, 3));
        r_end   = (n < 0) ? 32'h7fffffff : r_start + n;
        base    = sent_pix.size();
        for (int p = 0; p < n; p++) sent_pix.push_back(seq_pix ? p : int'($urandom_range(0, 255)));
      end
      prev_cv = lcd.cmd_valid;
      if (active && load && cyc > cmd_cyc && cyc <= cmd_cyc + IMG_PIXELS) begin
        if (lcd.datain !== img[cyc - cmd_cyc - 1]) ob_dbad++;
        if (cyc - cmd_cyc - 1 == abort_k) begin
          reset = 1'b1;
          lcd.busy = 1'b0; lcd.output_valid = 1'b0;
          return;
        end
      end
      if (o_win_we) begin
        ob_wa.push_back(int'(o_win_addr));
        ob_wd.push_back(int'(o_win_data));
      end
      if (o_resp_done) ob_resp++;
      if (o_err && ob_err_lat < 0) ob_err_lat = cyc - cmd_cyc;
      if (o_done) begin
        ob_done = 1'b1;
        ob_err  = o_err;
        lcd.busy = 1'b0; lcd.output_valid = 1'b0;
        return;
      end
      i_start          = (cyc == mid_start);
      lcd.busy         = active && cyc > cmd_cyc && cyc < r_end;
      lcd.output_valid = active && cyc >= r_start && cyc < r_end;
      lcd.dataout      = lcd.output_valid ? 8'(sent_pix[base + cyc - r_start]) : 8'($urandom);
      @(posedge clk); #1;
    end
    ob_timeout = 1'b1;
    i_start = 1'b0; lcd.busy = 1'b0; lcd.output_valid = 1'b0;
  endtask

  task automatic test_reset();
    int seen = 0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (outs() !== '0) begin errors++; $display("FAIL reset_outs got %h want 0", outs()); end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (outs() !== '0) begin errors++; $display("FAIL idle_outs got %h want 0", outs()); end
    lcd.output_valid = 1'b1; lcd.dataout = 8'hA5;
    repeat (4) begin
      @(posedge clk); #1;
      if (o_win_we || lcd.cmd_valid) seen++;
    end
    lcd.output_valid = 1'b0;
    checks++; if (seen != 0) begin errors++; $display("FAIL idle_ov_ignored got %0d want 0", seen); end
  endtask

  task automatic test_single_load();
    scr = '{0}; setup(16);
    run_script(-1, -1, 1'b1); build_exp();
    checks++; if (ob_timeout) begin errors++; $display("FAIL t1_budget got 1 want 0"); end
    checks++; if (cmd_diff() != 0) begin errors++; $display("FAIL t1_cmds got %0d want %0d", ob_cmds.size(), exp_cmds.size()); end
    checks++; if (ob_dbad != 0) begin errors++; $display("FAIL t1_datain got %0d bad want 0", ob_dbad); end
    checks++; if (wr_diff() != 0) begin errors++; $display("FAIL t1_writes got %0d want %0d", ob_wa.size(), exp_wa.size()); end
    checks++; if (ob_resp != exp_resp) begin errors++; $display("FAIL t1_resp got %0d want %0d", ob_resp, exp_resp); end
    checks++; if (ob_bviol + ob_b2b != 0) begin errors++; $display("FAIL t1_proto got %0d want 0", ob_bviol + ob_b2b); end
    checks++; if ({ob_done, ob_err} !== 2'b10) begin errors++; $display("FAIL t1_done_err got %b want 10", {ob_done, ob_err}); end
  endtask

  task automatic test_multi_cmd();
    scr = '{0, 1, 3, 5}; setup(16);
    run_script(-1, -1, 1'b0); build_exp();
    checks++; if (cmd_diff() != 0) begin errors++; $display("FAIL t2_cmds got %0d want %0d", ob_cmds.size(), exp_cmds.size()); end
    checks++; if (ob_resp != 4) begin errors++; $display("FAIL t2_resp got %0d want 4", ob_resp); end
    checks++; if (ob_bviol + ob_b2b != 0) begin errors++; $display("FAIL t2_proto got %0d want 0", ob_bviol + ob_b2b); end
    checks++; if (wr_diff() != 0) begin errors++; $display("FAIL t2_writes got %0d want %0d", ob_wa.size(), exp_wa.size()); end
    checks++; if ({ob_done, ob_err} !== 2'b10) begin errors++; $display("FAIL t2_done_err got %b want 10", {ob_done, ob_err}); end
  endtask

  task automatic test_short_reply();
    scr = '{1, 2}; setup(16); npix_a[0] = 15;
    run_script(-1, -1, 1'b0); build_exp();
    checks++; if (cmd_diff() != 0) begin errors++; $display("FAIL t3_cmds got %0d want %0d", ob_cmds.size(), exp_cmds.size()); end
    checks++; if (wr_diff() != 0) begin errors++; $display("FAIL t3_writes got %0d want %0d", ob_wa.size(), exp_wa.size()); end
    checks++; if ({ob_done, ob_err} !== 2'b11) begin errors++; $display("FAIL t3_done_err got %b want 11", {ob_done, ob_err}); end
    scr = '{3}; setup(16); npix_a[0] = 20;
    run_script(-1, -1, 1'b0); build_exp();
    checks++; if (wr_diff() != 0) begin errors++; $display("FAIL t3_long_writes got %0d want %0d", ob_wa.size(), exp_wa.size()); end
    checks++; if ({ob_done, ob_err} !== 2'b11) begin errors++; $display("FAIL t3_long_done_err got %b want 11", {ob_done, ob_err}); end
  endtask

  task automatic test_timeout();
    scr = '{2, 4}; setup(16); npix_a[0] = -1;
    run_script(-1, -1, 1'b0); build_exp();
    checks++; if (ob_timeout) begin errors++; $display("FAIL t4_budget got 1 want 0"); end
    checks++; if (cmd_diff() != 0) begin errors++; $display("FAIL t4_cmds got %0d want %0d", ob_cmds.size(), exp_cmds.size()); end
    checks++; if (ob_resp != exp_resp) begin errors++; $display("FAIL t4_resp got %0d want %0d", ob_resp, exp_resp); end
    checks++; if ({ob_done, ob_err} !== 2'b11) begin errors++; $display("FAIL t4_done_err got %b want 11", {ob_done, ob_err}); end
    checks++;
    if (ob_err_lat < TIMEOUT || ob_err_lat > TIMEOUT + 4) begin
      errors++; $display("FAIL t4_latency got %0d want %0d..%0d", ob_err_lat, TIMEOUT, TIMEOUT + 4);
    end
  endtask

  task automatic test_reset_mid_load();
    scr = '{0}; setup(16);
    run_script(50, -1, 1'b0);
    checks++; if (ob_dbad != 0) begin errors++; $display("FAIL t5_pre_datain got %0d bad want 0", ob_dbad); end
    @(posedge clk); #1;
    checks++; if (outs() !== '0) begin errors++; $display("FAIL t5_reset_outs got %h want 0", outs()); end
    reset = 1'b0;
    @(posedge clk); #1;
    run_script(-1, -1, 1'b0); build_exp();
    checks++; if (ob_dbad != 0) begin errors++; $display("FAIL t5_datain got %0d bad want 0", ob_dbad); end
    checks++; if (wr_diff() != 0) begin errors++; $display("FAIL t5_writes got %0d want %0d", ob_wa.size(), exp_wa.size()); end
    checks++; if ({ob_done, ob_err} !== 2'b10) begin errors++; $display("FAIL t5_done_err got %b want 10", {ob_done, ob_err}); end
  endtask

  task automatic test_start_handling();
    scr = '{2, 0}; setup(16); npix_a[0] = 15;
    run_script(-1, 40, 1'b0); build_exp();
    checks++; if (cmd_diff() != 0) begin errors++; $display("FAIL t6_mid_cmds got %0d want %0d", ob_cmds.size(), exp_cmds.size()); end
    checks++; if (ob_resp != 2) begin errors++; $display("FAIL t6_mid_resp got %0d want 2", ob_resp); end
    checks++; if ({ob_done, ob_err} !== 2'b11) begin errors++; $display("FAIL t6_mid_done_err got %b want 11", {ob_done, ob_err}); end
    setup(16);
    run_script(-1, -1, 1'b0); build_exp();
    checks++; if ({ob_done_as, ob_err_as} !== 2'b00) begin errors++; $display("FAIL t6_clear got %b want 00", {ob_done_as, ob_err_as}); end
    checks++; if (cmd_diff() != 0) begin errors++; $display("FAIL t6_rerun_cmds got %0d want %0d", ob_cmds.size(), exp_cmds.size()); end
    checks++; if ({ob_done, ob_err} !== 2'b10) begin errors++; $display("FAIL t6_rerun_done_err got %b want 10", {ob_done, ob_err}); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      int len = int'($urandom_range(1, 4));
      scr.delete();
      for (int i = 0; i < len; i++) scr.push_back(int'($urandom_range(0, 14)));
      setup(16);
      for (int i = 0; i < len; i++)
        if ($urandom_range(0, 3) == 0) npix_a[i] = int'($urandom_range(14, 18));
      run_script(-1, -1, 1'b0); build_exp();
      checks++; if (ob_timeout) begin errors++; $display("FAIL rnd%0d_budget got 1 want 0", it); end
      checks++; if (cmd_diff() != 0) begin errors++; $display("FAIL rnd%0d_cmds got %0d want %0d", it, ob_cmds.size(), exp_cmds.size()); end
      checks++; if (ob_dbad + ob_bviol + ob_b2b != 0) begin errors++; $display("FAIL rnd%0d_stream got %0d want 0", it, ob_dbad + ob_bviol + ob_b2b); end
      checks++; if (wr_diff() != 0) begin errors++; $display("FAIL rnd%0d_writes got %0d want %0d", it, ob_wa.size(), exp_wa.size()); end
      checks++; if (ob_resp != exp_resp) begin errors++; $display("FAIL rnd%0d_resp got %0d want %0d", it, ob_resp, exp_resp); end
      checks++; if ({ob_done, ob_err} !== {1'b1, exp_err}) begin errors++; $display("FAIL rnd%0d_done_err got %b want %b", it, {ob_done, ob_err}, {1'b1, exp_err}); end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    i_start = 1'b0;
    lcd.busy = 1'b0;
    lcd.output_valid = 1'b0;
    lcd.dataout = 8'h00;
    for (int i = 0; i < 128; i++) img[i] = (i < IMG_PIXELS) ? 8'($urandom) : 8'h00;
    for (int i = 0; i < 64; i++) rom[i] = 4'hF;
    test_reset();
    test_single_load();
    test_multi_cmd();
    test_short_reply();
    test_timeout();
    test_reset_mid_load();
    test_start_handling();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
